// File: rtl/sched_pkg.sv
// Shared scheduler definitions: port count, default AXIS widths, sume_meta
// field positions and the dequeue agent FSM encoding.
package sched_pkg;

   localparam int NUM_PORTS = 5;

   localparam int DEF_DW = 256;
   localparam int DEF_UW = 128;

   localparam int TUSER_DST_LO   = 24;
   localparam int TUSER_DST_HI   = 31;
   localparam int TUSER_DROP_BIT = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_POP    = 2'd1,
      ST_STREAM = 2'd2
   } dq_state_e;

   function automatic logic [7:0] tuser_dst(input logic [DEF_UW-1:0] tuser);
      return tuser[TUSER_DST_HI:TUSER_DST_LO];
   endfunction

   function automatic logic tuser_drop(input logic [DEF_UW-1:0] tuser);
      return tuser[TUSER_DROP_BIT];
   endfunction

endpackage

// File: rtl/dq_skid_fifo.sv
// Two-entry register FIFO; the head lives in its own register so the
// consumer sees registered data, and occupancy is exported for credit gating.
module dq_skid_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         valid,
   output logic [1:0]   occ
);

   logic [W-1:0] slot1;
   logic         pop_ok;

   assign valid  = (occ != 2'd0);
   assign pop_ok = pop && valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the data slots are reset too, because the head drives module
      // outputs that must read zero while reset is asserted.
      if (!rst_n) begin
         head  <= '0;
         slot1 <= '0;
         occ   <= 2'd0;
      end else begin
         if (push && pop_ok) begin
            if (occ == 2'd2) begin
               head  <= slot1;
               slot1 <= push_data;
            end else begin
               head <= push_data;
            end
         end else if (push) begin
            if (occ == 2'd0) head <= push_data;
            else             slot1 <= push_data;
            occ <= occ + 2'd1;
         end else if (pop_ok) begin
            head <= slot1;
            occ  <= occ - 2'd1;
         end
      end
   end

endmodule

// File: rtl/dequeue_agent_v0_1.sv
// Per-port dequeue agent: pops one PIFO token per packet, then reads that
// packet's chunks from the port buffer up to tlast and streams them out on AXIS.
module dequeue_agent_v0_1
   import sched_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = DEF_DW,
   parameter int C_M_AXIS_TUSER_WIDTH = DEF_UW,
   parameter int PORT_ID              = 0
) (
   input  logic                              axis_aclk,
   input  logic                              axis_resetn,
   input  logic                              s_axis_pifo_empty,
   output logic                              m_axis_ctl_pifo_out_en,
   input  logic                              s_axis_buffer_empty,
   output logic                              m_axis_ctl_buffer_rd_en,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_buffer_tdata,
   input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_buffer_tkeep,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_buffer_tuser,
   input  logic                              s_axis_buffer_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast
);

   localparam int DW = C_M_AXIS_DATA_WIDTH;
   localparam int KW = C_M_AXIS_DATA_WIDTH / 8;
   localparam int UW = C_M_AXIS_TUSER_WIDTH;
   localparam int FW = DW + KW + UW + 1;

   // Instance index only labels the port; an out-of-range value elaborates nothing extra.
   if (PORT_ID >= NUM_PORTS) begin : g_port_id_out_of_range
   end

   dq_state_e    state, state_next;
   logic         rd_valid_q;
   logic         last_back;
   logic         pop;
   logic [1:0]   occ;
   logic [2:0]   fill_next;
   logic [FW-1:0] wr_data;
   logic [FW-1:0] head;

   assign pop       = m_axis_tvalid && m_axis_tready;
   assign last_back = rd_valid_q && s_axis_buffer_tlast;

   // Entries the FIFO will hold after this cycle, counting the chunk now returning.
   assign fill_next = {1'b0, occ} + {2'b00, rd_valid_q} - {2'b00, pop};

   assign m_axis_ctl_buffer_rd_en = (state == ST_STREAM) && !s_axis_buffer_empty &&
                                    !last_back && (fill_next < 3'd2);

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state      <= ST_IDLE;
         rd_valid_q <= 1'b0;
      end else begin
         state      <= state_next;
         rd_valid_q <= m_axis_ctl_buffer_rd_en;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a value unassigned and no latch is inferred.
      state_next             = state;
      m_axis_ctl_pifo_out_en = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!s_axis_pifo_empty) state_next = ST_POP;
         end
         ST_POP: begin
            m_axis_ctl_pifo_out_en = 1'b1;
            state_next             = ST_STREAM;
         end
         ST_STREAM: begin
            if (last_back) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign wr_data = {s_axis_buffer_tdata, s_axis_buffer_tkeep, s_axis_buffer_tuser, s_axis_buffer_tlast};

   dq_skid_fifo #(.W(FW)) u_fifo (
      .clk       (axis_aclk),
      .rst_n     (axis_resetn),
      .push      (rd_valid_q),
      .push_data (wr_data),
      .pop       (pop),
      .head      (head),
      .valid     (m_axis_tvalid),
      .occ       (occ)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = head;

endmodule

// File: tb/tb_dequeue_agent_v0_1.sv
// Scoreboarded bench for dequeue_agent_v0_1 with PIFO/buffer models around the DUT.
module tb_dequeue_agent_v0_1;
   import sched_pkg::*;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   localparam int BW = $bits(beat_t);

   logic          axis_aclk = 1'b0;
   logic          axis_resetn = 1'b0;
   logic          s_axis_pifo_empty = 1'b1;
   logic          m_axis_ctl_pifo_out_en;
   logic          s_axis_buffer_empty = 1'b1;
   logic          m_axis_ctl_buffer_rd_en;
   logic [DW-1:0] s_axis_buffer_tdata = '0;
   logic [KW-1:0] s_axis_buffer_tkeep = '0;
   logic [UW-1:0] s_axis_buffer_tuser = '0;
   logic          s_axis_buffer_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;

   always #5 axis_aclk = ~axis_aclk;

   dequeue_agent_v0_1 #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .PORT_ID              (0)
   ) dut (
      .axis_aclk               (axis_aclk),
      .axis_resetn             (axis_resetn),
      .s_axis_pifo_empty       (s_axis_pifo_empty),
      .m_axis_ctl_pifo_out_en  (m_axis_ctl_pifo_out_en),
      .s_axis_buffer_empty     (s_axis_buffer_empty),
      .m_axis_ctl_buffer_rd_en (m_axis_ctl_buffer_rd_en),
      .s_axis_buffer_tdata     (s_axis_buffer_tdata),
      .s_axis_buffer_tkeep     (s_axis_buffer_tkeep),
      .s_axis_buffer_tuser     (s_axis_buffer_tuser),
      .s_axis_buffer_tlast     (s_axis_buffer_tlast),
      .m_axis_tdata            (m_axis_tdata),
      .m_axis_tkeep            (m_axis_tkeep),
      .m_axis_tuser            (m_axis_tuser),
      .m_axis_tvalid           (m_axis_tvalid),
      .m_axis_tready           (m_axis_tready),
      .m_axis_tlast            (m_axis_tlast)
   );

   int    n_pass = 0;
   int    n_total = 0;
   int    cyc = 0;
   beat_t buf_q[$];
   beat_t exp_q[$];
   int    beat_cyc[$];
   int    tokens = 0;
   bit    gap = 0, rand_gap = 0, rand_ready = 0;
   logic  ready_val = 1'b1;
   int    issued = 0, accepted = 0, rd_cnt = 0, pop_cnt = 0;
   bit    pkt_open = 0;
   bit    stall_pend = 0;
   beat_t stall_beat;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic beat_t rand_beat(input bit last);
      beat_t b;
      for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
      b.keep = $urandom;
      b.user = {$urandom, $urandom, $urandom, $urandom};
      b.last = last;
      return b;
   endfunction

   task automatic refresh();
      s_axis_pifo_empty   = (tokens == 0);
      s_axis_buffer_empty = (buf_q.size() == 0) || gap;
   endtask

   always @(posedge axis_aclk) cyc <= cyc + 1;

   always begin
      @(posedge axis_aclk);
      #2;
      m_axis_tready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_val;
   end

   // PIFO and packet-buffer models: tokens pop on the strobe, chunks return one cycle after rd_en.
   always begin : bus_model
      beat_t b;
      bit rd_seen, pop_seen, beat_seen;
      @(negedge axis_aclk);
      rd_seen = 0; pop_seen = 0; beat_seen = 0;
      if (axis_resetn) begin
         rd_seen   = m_axis_ctl_buffer_rd_en;
         pop_seen  = m_axis_ctl_pifo_out_en;
         beat_seen = m_axis_tvalid && m_axis_tready;
         if (pop_seen) begin
            pop_cnt++;
            check("pop_has_token", tokens > 0, 1);
            pkt_open = 1;
         end
         if (rd_seen) begin
            rd_cnt++;
            check("rd_en_while_empty", s_axis_buffer_empty, 0);
            check("rd_en_outside_packet", pkt_open, 1);
            check("rd_en_credit", (issued - accepted - int'(beat_seen) + 1) <= 2, 1);
         end
      end
      @(posedge axis_aclk);
      #1;
      if (axis_resetn) begin
         if (beat_seen) accepted++;
         if (pop_seen && tokens > 0) tokens--;
         if (rd_seen && buf_q.size() > 0) begin
            issued++;
            b = buf_q.pop_front();
            if (b.last) pkt_open = 0;
         end else begin
            b = rand_beat($urandom_range(0, 1) == 1);
         end
         {s_axis_buffer_tdata, s_axis_buffer_tkeep, s_axis_buffer_tuser, s_axis_buffer_tlast} = b;
         if (rand_gap) gap = ($urandom_range(0, 4) == 0);
         refresh();
      end
   end

   // Scoreboard monitor: every accepted beat is popped from the expected queue.
   always @(negedge axis_aclk) begin
      beat_t cur;
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      if (axis_resetn) begin
         if (stall_pend) begin
            check("tvalid_held", m_axis_tvalid, 1);
            check("beat_stable", cur, stall_beat);
         end
         stall_pend = 0;
         if (m_axis_tvalid) begin
            if (m_axis_tready) begin
               check("beat_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("beat_data", cur, exp_q.pop_front());
               beat_cyc.push_back(cyc);
            end else begin
               stall_pend = 1;
               stall_beat = cur;
            end
         end
      end
   end

   task automatic load_packet(input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b = rand_beat(i == len - 1);
         buf_q.push_back(b);
         exp_q.push_back(b);
      end
      tokens++;
      refresh();
   endtask

   task automatic step();
      @(posedge axis_aclk);
      #3;
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || tokens != 0 || issued != accepted) && k < budget) begin
         @(negedge axis_aclk);
         k++;
      end
      check({name, "_drained"}, (exp_q.size() == 0 && tokens == 0 && issued == accepted), 1);
      repeat (3) @(negedge axis_aclk);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0, p0, c0, k, rg;
      beat_t zero_beat;
      logic pat [5];
      zero_beat = '0;
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
      refresh();
      repeat (3) @(negedge axis_aclk);
      check("reset_ctrl", {m_axis_tvalid, m_axis_ctl_pifo_out_en, m_axis_ctl_buffer_rd_en}, 0);
      check("reset_data", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, zero_beat);
      axis_resetn = 1'b1;
      repeat (2) step();

      // 3-chunk packet, first beat 4 cycles after the PIFO goes non-empty
      rd0 = rd_cnt; p0 = pop_cnt; beat_cyc.delete(); ready_val = 1;
      load_packet(3);
      c0 = cyc;
      drain("t1", 60);
      check("t1_pops", pop_cnt - p0, 1);
      check("t1_reads", rd_cnt - rd0, 3);
      check("t1_beats", beat_cyc.size(), 3);
      if (beat_cyc.size() == 3) begin
         check("t1_first_valid_cycle", beat_cyc[0] - c0, 4);
         check("t1_back_to_back", beat_cyc[2] - beat_cyc[0], 2);
      end

      // two back-to-back 2-chunk packets
      rd0 = rd_cnt; p0 = pop_cnt; beat_cyc.delete();
      load_packet(2);
      load_packet(2);
      drain("t2", 80);
      check("t2_pops", pop_cnt - p0, 2);
      check("t2_reads", rd_cnt - rd0, 4);
      check("t2_beats", beat_cyc.size(), 4);

      // tready 1,0,0,1,1 during a 4-chunk packet
      rd0 = rd_cnt; beat_cyc.delete();
      load_packet(4);
      k = 0;
      do begin @(negedge axis_aclk); k++; end while (!m_axis_tvalid && k < 20);
      check("t3_tvalid_seen", m_axis_tvalid, 1);
      for (int i = 1; i < 5; i++) begin
         @(posedge axis_aclk);
         #1;
         ready_val = pat[i];
      end
      @(posedge axis_aclk);
      #1;
      ready_val = 1;
      drain("t3", 80);
      check("t3_reads", rd_cnt - rd0, 4);
      check("t3_beats", beat_cyc.size(), 4);

      // buffer empty for 5 cycles mid-packet
      rd0 = rd_cnt; beat_cyc.delete();
      load_packet(4);
      k = 0;
      while (rd_cnt - rd0 < 2 && k < 20) begin @(negedge axis_aclk); k++; end
      step();
      gap = 1; refresh();
      rg = rd_cnt;
      repeat (5) step();
      check("t4_no_reads_in_gap", rd_cnt - rg, 0);
      gap = 0; refresh();
      drain("t4", 80);
      check("t4_reads", rd_cnt - rd0, 4);
      check("t4_beats", beat_cyc.size(), 4);

      // reset with one chunk in the FIFO and one read in flight
      ready_val = 0;
      step();
      load_packet(4);
      k = 0;
      do begin @(negedge axis_aclk); k++; end while (!m_axis_tvalid && k < 20);
      check("t5_inflight", issued - accepted, 2);
      #2;
      axis_resetn = 1'b0;
      #1;
      check("t5_async_ctrl", {m_axis_tvalid, m_axis_ctl_pifo_out_en, m_axis_ctl_buffer_rd_en}, 0);
      check("t5_async_data", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, zero_beat);
      buf_q.delete(); exp_q.delete();
      tokens = 0; gap = 0; issued = 0; accepted = 0; pkt_open = 0; stall_pend = 0;
      refresh();
      @(negedge axis_aclk);
      #2;
      axis_resetn = 1'b1;
      ready_val = 1;
      step();
      rd0 = rd_cnt; p0 = pop_cnt; beat_cyc.delete();
      load_packet(3);
      c0 = cyc;
      drain("t5", 60);
      check("t5_pops", pop_cnt - p0, 1);
      check("t5_reads", rd_cnt - rd0, 3);
      check("t5_beats", beat_cyc.size(), 3);
      if (beat_cyc.size() > 0) check("t5_first_valid_cycle", beat_cyc[0] - c0, 4);

      // single-chunk packet
      rd0 = rd_cnt; beat_cyc.delete();
      load_packet(1);
      drain("t6", 40);
      check("t6_reads", rd_cnt - rd0, 1);
      check("t6_beats", beat_cyc.size(), 1);

      // randomized packets, backpressure and buffer gaps
      rand_ready = 1; rand_gap = 1;
      rd0 = rd_cnt; p0 = pop_cnt; beat_cyc.delete(); k = 0;
      for (int p = 0; p < 25; p++) begin
         rg = $urandom_range(1, 6);
         k += rg;
         load_packet(rg);
         repeat ($urandom_range(0, 8)) step();
      end
      drain("rand", 3000);
      rand_gap = 0; gap = 0; rand_ready = 0; ready_val = 1;
      refresh();
      check("rand_pops", pop_cnt - p0, 25);
      check("rand_reads", rd_cnt - rd0, k);
      check("rand_beats", beat_cyc.size(), k);

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
